// File: rtl/resource_pool_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resource_pool_lock_pkg
// Description : Shared types and width helpers for the resource pool lock.
//               Holds the per-SIC request bundle (req / issue ID / release
//               pulse) and the helper used to derive select widths.
// Revision    : 1.0 - initial release
// ============================================================================
package resource_pool_lock_pkg;

    // Issue ID width carried in the request bundle.
    localparam int RPL_ID_WIDTH = 4;

    // Request bundle driven by each SIC toward a pool.
    typedef struct packed {
        logic                    req;           // level request
        logic [RPL_ID_WIDTH-1:0] req_issue_id;  // issue ID of the requester
        logic                    release_lock;  // one-cycle release pulse
    } rpl_req_t;

    // Index width for n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/resource_pool_lock_age_picker.sv
`default_nettype none
// ============================================================================
// Module      : rpl_age_picker
// Description : Combinational oldest-first selector. Among the pending SICs
//               it returns the one whose issue ID is closest after
//               oldest_issue_id (modulo 2^ID_WIDTH); ties go to the lower
//               SIC index.
// Ports       : i_pending  - candidate mask, one bit per SIC
//               i_ids      - issue ID per SIC
//               i_oldest   - age reference (oldest in-flight issue ID)
//               o_valid    - at least one candidate present
//               o_winner   - index of the selected SIC (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rpl_age_picker
    import resource_pool_lock_pkg::*;
#(
    parameter int NUM_SICS = 4,
    parameter int ID_WIDTH = RPL_ID_WIDTH,
    localparam int SIC_W   = idx_width(NUM_SICS)
) (
    input  logic [NUM_SICS-1:0]               i_pending,
    input  logic [NUM_SICS-1:0][ID_WIDTH-1:0] i_ids,
    input  logic [ID_WIDTH-1:0]               i_oldest,
    output logic                              o_valid,
    output logic [SIC_W-1:0]                  o_winner
);

    logic [ID_WIDTH-1:0] w_age;
    logic [ID_WIDTH-1:0] w_best_age;

    // Linear scan in ascending index; a strict "less than" keeps the lower
    // index on equal age.
    always_comb begin
        o_valid    = 1'b0;
        o_winner   = '0;
        w_best_age = '0;
        w_age      = '0;
        for (int i = 0; i < NUM_SICS; i++) begin
            // Unsigned subtraction wraps, giving the distance past oldest.
            w_age = i_ids[i] - i_oldest;
            if (i_pending[i] && (!o_valid || (w_age < w_best_age))) begin
                o_valid    = 1'b1;
                o_winner   = SIC_W'(i);
                w_best_age = w_age;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/resource_pool_lock.sv
`default_nettype none
// ============================================================================
// Module      : resource_pool_lock
// Description : Lock arbiter for a pool of identical shared resources.
//               Pending SICs are granted free instances oldest-first; a grant
//               is held until the owner pulses release_lock, independent of
//               the owner's req level.
// Ports       : clk             - clock, rising edge
//               rst             - synchronous active-high reset
//               sic_rpl         - per-SIC request bundle
//               oldest_issue_id - age reference for wrap-around ordering
//               grant           - SIC i owns an instance
//               grant_res       - instance owned by SIC i (0 when no grant)
//               res_busy        - instance r has an owner
//               res_owner       - owner of instance r (0 when idle)
// Revision    : 1.0 - initial release
// ============================================================================
module resource_pool_lock
    import resource_pool_lock_pkg::*;
#(
    parameter int NUM_SICS = 4,
    parameter int NUM_RES  = 1,
    parameter int ID_WIDTH = RPL_ID_WIDTH,
    localparam int SIC_W   = idx_width(NUM_SICS),
    localparam int RES_W   = idx_width(NUM_RES)
) (
    input  logic                clk,
    input  logic                rst,
    input  rpl_req_t            sic_rpl [NUM_SICS],
    input  logic [ID_WIDTH-1:0] oldest_issue_id,
    output logic                grant [NUM_SICS],
    output logic [RES_W-1:0]    grant_res [NUM_SICS],
    output logic                res_busy [NUM_RES],
    output logic [SIC_W-1:0]    res_owner [NUM_RES]
);

    // Per-instance lock state; owner is kept at 0 whenever the instance idles.
    logic                r_busy  [NUM_RES];
    logic [SIC_W-1:0]    r_owner [NUM_RES];

    logic [NUM_SICS-1:0]               w_owns;
    logic [NUM_SICS-1:0]               w_pending;
    logic [NUM_SICS-1:0][ID_WIDTH-1:0] w_ids;
    logic [RES_W-1:0]                  w_owned_res [NUM_SICS];
    logic                              w_releasing [NUM_RES];
    logic                              w_free      [NUM_RES];
    logic                              w_take      [NUM_RES];
    logic [SIC_W-1:0]                  w_take_sic  [NUM_RES];

    // Ownership view, release detection and the pending set.
    always_comb begin
        for (int i = 0; i < NUM_SICS; i++) begin
            w_owns[i]      = 1'b0;
            w_owned_res[i] = '0;
            w_ids[i]       = sic_rpl[i].req_issue_id;
        end
        for (int r = 0; r < NUM_RES; r++) begin
            if (r_busy[r]) begin
                w_owns[r_owner[r]]      = 1'b1;
                w_owned_res[r_owner[r]] = RES_W'(r);
            end
        end
        // An owner is never pending, even in its release cycle, so a SIC
        // that releases and requests together is not re-granted that edge.
        for (int i = 0; i < NUM_SICS; i++) begin
            w_pending[i] = sic_rpl[i].req && !w_owns[i];
        end
        // Only the recorded owner's pulse frees an instance.
        for (int r = 0; r < NUM_RES; r++) begin
            w_releasing[r] = r_busy[r] && sic_rpl[r_owner[r]].release_lock;
            w_free[r]      = !r_busy[r] || w_releasing[r];
        end
    end

    // One picker per instance slot. Each slot sees the pending set minus the
    // SICs claimed by lower-indexed free slots, so free instances fill in
    // ascending order with ascending-age requesters.
    for (genvar r = 0; r < NUM_RES; r++) begin : g_slot
        logic [NUM_SICS-1:0] w_mask_in;
        logic                w_valid;
        logic [SIC_W-1:0]    w_winner;

        if (r == 0) begin : g_first
            assign w_mask_in = w_pending;
        end else begin : g_chain
            assign w_mask_in = g_slot[r-1].g_pass.w_mask_out;
        end

        rpl_age_picker #(
            .NUM_SICS (NUM_SICS),
            .ID_WIDTH (ID_WIDTH)
        ) u_picker (
            .i_pending (w_mask_in),
            .i_ids     (w_ids),
            .i_oldest  (oldest_issue_id),
            .o_valid   (w_valid),
            .o_winner  (w_winner)
        );

        assign w_take[r]     = w_free[r] && w_valid;
        assign w_take_sic[r] = w_winner;

        if (r < NUM_RES - 1) begin : g_pass
            logic [NUM_SICS-1:0] w_mask_out;
            assign w_mask_out = w_take[r]
                              ? (w_mask_in & ~(NUM_SICS'(1) << w_winner))
                              : w_mask_in;
        end
    end

    // A new grant takes priority over the release it replaces, which gives
    // the same-edge handover with no idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_RES; r++) begin
                r_busy[r]  <= 1'b0;
                r_owner[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_RES; r++) begin
                if (w_take[r]) begin
                    r_busy[r]  <= 1'b1;
                    r_owner[r] <= w_take_sic[r];
                end else if (w_releasing[r]) begin
                    r_busy[r]  <= 1'b0;
                    r_owner[r] <= '0;
                end
            end
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        for (int i = 0; i < NUM_SICS; i++) begin
            grant[i]     = w_owns[i];
            grant_res[i] = w_owned_res[i];
        end
        for (int r = 0; r < NUM_RES; r++) begin
            res_busy[r]  = r_busy[r];
            res_owner[r] = r_owner[r];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_resource_pool_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_resource_pool_lock
// Description : Bench for resource_pool_lock. Drives a one-instance pool and
//               a two-instance pool from the same SIC requests and compares
//               both against an oldest-first reference model every cycle,
//               plus literal expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resource_pool_lock;
    import resource_pool_lock_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    rpl_req_t   sic_rpl [4];
    logic [3:0] oldest;

    logic       g1  [4];
    logic [0:0] gr1 [4];
    logic       rb1 [1];
    logic [1:0] ro1 [1];
    logic       g2  [4];
    logic [0:0] gr2 [4];
    logic       rb2 [2];
    logic [1:0] ro2 [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit m_busy  [2][2];
    int m_owner [2][2];

    always #5 clk = ~clk;

    resource_pool_lock #(.NUM_SICS(4), .NUM_RES(1), .ID_WIDTH(4)) u_dut1 (
        .clk (clk), .rst (rst), .sic_rpl (sic_rpl), .oldest_issue_id (oldest),
        .grant (g1), .grant_res (gr1), .res_busy (rb1), .res_owner (ro1)
    );

    resource_pool_lock #(.NUM_SICS(4), .NUM_RES(2), .ID_WIDTH(4)) u_dut2 (
        .clk (clk), .rst (rst), .sic_rpl (sic_rpl), .oldest_issue_id (oldest),
        .grant (g2), .grant_res (gr2), .res_busy (rb2), .res_owner (ro2)
    );

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, idx, act, exp, $time);
        end
    endtask

    function automatic int age(input int i);
        logic [3:0] a;
        a = sic_rpl[i].req_issue_id - oldest;
        return int'(a);
    endfunction

    // Reference: release owned instances, then give each free instance (low
    // index first) to the youngest-age pending SIC not yet served this edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit nb [2];
            int no [2];
            bit owns [4];
            bit taken [4];
            int best;
            for (int r = 0; r < 2; r++) begin nb[r] = 0; no[r] = 0; end
            for (int i = 0; i < 4; i++) begin owns[i] = 0; taken[i] = 0; end
            if (!rst) begin
                for (int r = 0; r < k + 1; r++) begin
                    if (m_busy[k][r]) begin
                        owns[m_owner[k][r]] = 1;
                        nb[r] = 1;
                        no[r] = m_owner[k][r];
                        if (sic_rpl[m_owner[k][r]].release_lock) begin
                            nb[r] = 0;
                            no[r] = 0;
                        end
                    end
                end
                for (int r = 0; r < k + 1; r++) begin
                    if (!nb[r]) begin
                        best = -1;
                        for (int i = 0; i < 4; i++)
                            if (sic_rpl[i].req && !owns[i] && !taken[i] &&
                                (best < 0 || age(i) < age(best)))
                                best = i;
                        if (best >= 0) begin
                            nb[r] = 1;
                            no[r] = best;
                            taken[best] = 1;
                        end
                    end
                end
            end
            for (int r = 0; r < 2; r++) begin
                m_busy[k][r]  <= nb[r];
                m_owner[k][r] <= no[r];
            end
        end
    end

    function automatic int exp_grant(input int k, input int i);
        for (int r = 0; r < k + 1; r++)
            if (m_busy[k][r] && m_owner[k][r] == i) return 1;
        return 0;
    endfunction

    function automatic int exp_gres(input int k, input int i);
        for (int r = 0; r < k + 1; r++)
            if (m_busy[k][r] && m_owner[k][r] == i) return r;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk("m_grant_p1",     i, int'(g1[i]),  exp_grant(0, i));
                chk("m_grant_res_p1", i, int'(gr1[i]), exp_gres(0, i));
                chk("m_grant_p2",     i, int'(g2[i]),  exp_grant(1, i));
                chk("m_grant_res_p2", i, int'(gr2[i]), exp_gres(1, i));
            end
            chk("m_res_busy_p1",  0, int'(rb1[0]), int'(m_busy[0][0]));
            chk("m_res_owner_p1", 0, int'(ro1[0]), m_owner[0][0]);
            for (int r = 0; r < 2; r++) begin
                chk("m_res_busy_p2",  r, int'(rb2[r]), int'(m_busy[1][r]));
                chk("m_res_owner_p2", r, int'(ro2[r]), m_owner[1][r]);
            end
        end
    end

    task automatic set_req(input int i, input int id);
        sic_rpl[i].req          = 1'b1;
        sic_rpl[i].req_issue_id = 4'(id);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) sic_rpl[i] = '0;
        oldest = 4'd0;
        rst    = 1'b1;
        cyc(); cyc();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_grant_p1", 2, int'(g1[2]), 0);
        chk("rst_busy_p1",  0, int'(rb1[0]), 0);
        chk("rst_busy_p2",  1, int'(rb2[1]), 0);
        chk("rst_owner_p2", 0, int'(ro2[0]), 0);

        // Single request, one-cycle grant latency.
        set_req(2, 5);
        cyc();
        chk("t1_grant_p1", 2, int'(g1[2]), 1);
        chk("t1_owner_p1", 0, int'(ro1[0]), 2);
        chk("t1_owner_p2", 0, int'(ro2[0]), 2);
        chk("t1_busy_p2",  1, int'(rb2[1]), 0);
        // Owner drops req a cycle before release; stray pulse from SIC3.
        sic_rpl[2].req = 1'b0;
        sic_rpl[3].release_lock = 1'b1;
        cyc();
        sic_rpl[3].release_lock = 1'b0;
        chk("held_grant_p1", 2, int'(g1[2]), 1);
        chk("stray_owner_p1", 0, int'(ro1[0]), 2);
        sic_rpl[2].release_lock = 1'b1;
        cyc();
        sic_rpl[2].release_lock = 1'b0;
        chk("rel_grant_p1", 2, int'(g1[2]), 0);
        chk("rel_busy_p1",  0, int'(rb1[0]), 0);

        // Oldest-first: id 3 (age 1) beats id 7 (age 5).
        oldest = 4'd2;
        set_req(0, 7);
        set_req(3, 3);
        cyc();
        chk("age_grant3_p1", 3, int'(g1[3]), 1);
        chk("age_grant0_p1", 0, int'(g1[0]), 0);
        chk("age_gres3_p2",  3, int'(gr2[3]), 0);
        chk("age_gres0_p2",  0, int'(gr2[0]), 1);
        sic_rpl[3].req = 1'b0;
        cyc();
        sic_rpl[3].release_lock = 1'b1;
        cyc();
        sic_rpl[3].release_lock = 1'b0;
        chk("handover_grant0_p1", 0, int'(g1[0]), 1);
        chk("handover_grant3_p1", 3, int'(g1[3]), 0);
        chk("handover_busy_p1",   0, int'(rb1[0]), 1);
        sic_rpl[0].req = 1'b0;
        cyc();
        sic_rpl[0].release_lock = 1'b1;
        cyc();
        sic_rpl[0].release_lock = 1'b0;
        chk("idle_busy_p2", 1, int'(rb2[1]), 0);

        // Wrap-around: oldest 14, id 15 (age 1) beats id 1 (age 3).
        oldest = 4'd14;
        set_req(1, 1);
        set_req(2, 15);
        cyc();
        chk("wrap_grant2_p1", 2, int'(g1[2]), 1);
        chk("wrap_grant1_p1", 1, int'(g1[1]), 0);
        // SIC2 releases while still requesting: not re-granted this edge.
        sic_rpl[2].release_lock = 1'b1;
        cyc();
        sic_rpl[2].release_lock = 1'b0;
        chk("relreq_grant1_p1", 1, int'(g1[1]), 1);
        chk("relreq_grant2_p1", 2, int'(g1[2]), 0);
        chk("relreq_grant2_p2", 2, int'(g2[2]), 0);
        cyc();
        chk("regrant_grant2_p2", 2, int'(g2[2]), 1);
        chk("regrant_gres2_p2",  2, int'(gr2[2]), 0);
        sic_rpl[1].req = 1'b0;
        sic_rpl[2].req = 1'b0;
        cyc();
        sic_rpl[1].release_lock = 1'b1;
        sic_rpl[2].release_lock = 1'b1;
        cyc();
        sic_rpl[1].release_lock = 1'b0;
        sic_rpl[2].release_lock = 1'b0;
        chk("clean_busy_p2", 0, int'(rb2[0]), 0);
        chk("clean_busy_p1", 0, int'(rb1[0]), 0);

        // Two instances, three requesters.
        oldest = 4'd4;
        set_req(0, 4);
        set_req(1, 5);
        set_req(2, 6);
        cyc();
        chk("dual_gres0_p2",  0, int'(gr2[0]), 0);
        chk("dual_gres1_p2",  1, int'(gr2[1]), 1);
        chk("dual_grant1_p2", 1, int'(g2[1]), 1);
        chk("dual_grant2_p2", 2, int'(g2[2]), 0);
        sic_rpl[1].req = 1'b0;
        cyc();
        sic_rpl[1].release_lock = 1'b1;
        cyc();
        sic_rpl[1].release_lock = 1'b0;
        chk("dual_grant2_after_p2", 2, int'(g2[2]), 1);
        chk("dual_gres2_after_p2",  2, int'(gr2[2]), 1);
        chk("dual_owner0_p1",       0, int'(ro1[0]), 0);

        // Reset with both instances held.
        sic_rpl[0].req = 1'b0;
        sic_rpl[2].req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_busy0_p2",  0, int'(rb2[0]), 0);
        chk("mrst_busy1_p2",  1, int'(rb2[1]), 0);
        chk("mrst_grant2_p2", 2, int'(g2[2]), 0);
        chk("mrst_busy_p1",   0, int'(rb1[0]), 0);
        set_req(3, 9);
        cyc();
        chk("fresh_grant3_p1", 3, int'(g1[3]), 1);
        chk("fresh_grant3_p2", 3, int'(g2[3]), 1);
        chk("fresh_gres3_p2",  3, int'(gr2[3]), 0);
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
